// File: rtl/bin_to_bcd_stream.sv
// bin_to_bcd_stream: serial double-dabble binary to BCD converter with valid/ready on both sides; define BIN_TO_BCD_SIGNED_EN for two's-complement input
module bin_to_bcd_stream #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_ovf,
  output logic                out_neg,
  output logic                busy
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  if (BIN_W < 1 || BIN_W > 32 || DIGITS < 1 || DIGITS > 10) begin : g_bad_param
    $error("bin_to_bcd_stream: BIN_W must be 1..32 and DIGITS 1..10");
  end
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              sign_q, sign_d;
  logic [BW-1:0]     out_bcd_q, out_bcd_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_neg_q, out_neg_d;
  logic              in_sign;
  logic [BIN_W-1:0]  in_mag;
  logic [BW-1:0]     acc_adj;
  logic [BW-1:0]     acc_sh;
  logic [BIN_W-1:0]  bin_sh;
  logic              carry;
`ifdef BIN_TO_BCD_SIGNED_EN
  assign in_sign = in_data[BIN_W-1];
`else
  assign in_sign = 1'b0;
`endif
  assign in_mag = in_sign ? -in_data : in_data;
  // add-3 correction on every accumulator digit that is 5 or more
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++)
      acc_adj[4*i+:4] = acc_q[4*i+:4] >= 4'd5 ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
  end
  assign {carry, acc_sh, bin_sh} = {acc_adj, bin_q, 1'b0};
  // next-state: load in IDLE, shift in CONV, publish result on the extra CONV cycle, wait in HOLD
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sign_d    = sign_q;
    out_bcd_d = out_bcd_q;
    out_ovf_d = out_ovf_q;
    out_neg_d = out_neg_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = CONV;
        bin_d   = in_mag;
        acc_d   = '0;
        ovf_d   = 1'b0;
        sign_d  = in_sign;
        cnt_d   = CW'(BIN_W);
      end
      CONV: if (cnt_q != '0) begin
        acc_d = acc_sh;
        bin_d = bin_sh;
        ovf_d = ovf_q | carry;
        cnt_d = cnt_q - CW'(1);
      end else begin
        state_d   = HOLD;
        out_bcd_d = ovf_q ? {DIGITS{4'h9}} : acc_q;
        out_ovf_d = ovf_q;
        out_neg_d = sign_q;
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sign_q    <= 1'b0;
      out_bcd_q <= '0;
      out_ovf_q <= 1'b0;
      out_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sign_q    <= sign_d;
      out_bcd_q <= out_bcd_d;
      out_ovf_q <= out_ovf_d;
      out_neg_q <= out_neg_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == CONV;
  assign out_valid = state_q == HOLD;
  assign out_bcd   = out_bcd_q;
  assign out_ovf   = out_ovf_q;
  assign out_neg   = out_neg_q;
endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// tb_bin_to_bcd_stream: directed checks of bin_to_bcd_stream at 12-bit and 14-bit widths, unsigned or BIN_TO_BCD_SIGNED_EN builds
module tb_bin_to_bcd_stream;
`ifdef BIN_TO_BCD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf, out_neg, busy;
  logic [11:0] in_data;
  logic [15:0] out_bcd;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_out_neg, b_busy;
  logic [13:0] b_in_data;
  logic [15:0] b_out_bcd;
  int          n_chk = 0, n_fail = 0, cyc = 0, lat, last, w;
  logic [15:0] r_bcd;
  logic        r_ovf, r_neg, seen;
  logic [17:0] m;
  logic [11:0] vals [10] = '{12'd1, 12'd9, 12'd10, 12'd99, 12'd100, 12'd999, 12'd1000, 12'd2047, 12'd3210, 12'd4094};

  bin_to_bcd_stream #(.BIN_W(12), .DIGITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_ovf(out_ovf),
    .out_neg(out_neg), .busy(busy));

  bin_to_bcd_stream #(.BIN_W(14), .DIGITS(4)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bcd(b_out_bcd), .out_ovf(b_out_ovf),
    .out_neg(b_out_neg), .busy(b_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: {neg, ovf, bcd} for a w-bit input
  function automatic logic [17:0] mdl(input int v, input int wd);
    logic n, o;
    int   mg;
    logic [15:0] b;
    n  = SGN && (v >= (1 << (wd - 1)));
    mg = n ? (1 << wd) - v : v;
    o  = mg > 9999;
    b  = 16'h9999;
    if (!o) for (int i = 0; i < 4; i++) begin
      b[4*i+:4] = 4'(mg % 10);
      mg = mg / 10;
    end
    return {n, o, b};
  endfunction

  task automatic conv_a(input logic [11:0] v, input bit rel);
    in_valid = 1'b1; in_data = v; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    r_bcd = out_bcd; r_ovf = out_ovf; r_neg = out_neg;
    if (rel) begin out_ready = 1'b1; @(negedge clk); out_ready = 1'b0; end
  endtask

  task automatic conv_b(input logic [13:0] v);
    b_in_valid = 1'b1; b_in_data = v; b_out_ready = 1'b0;
    @(negedge clk);
    b_in_valid = 1'b0; lat = 0;
    while (!b_out_valid && lat < 100) begin @(negedge clk); lat++; end
    r_bcd = b_out_bcd; r_ovf = b_out_ovf; r_neg = b_out_neg;
    b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bcd", out_bcd, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_neg", out_neg, 0);
    chk("rst14_in_ready", b_in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    // max 12-bit value, latency and handshake
    conv_a(12'd4095, 1'b1);
    chk("max_lat", lat, 13);
    chk("max_bcd", r_bcd, SGN ? 16'h0001 : 16'h4095);
    chk("max_ovf", r_ovf, 0);
    chk("max_neg", r_neg, SGN);
    chk("max_valid_drop", out_valid, 0);
    chk("max_in_ready", in_ready, 1);
    conv_a(12'd0, 1'b1);
    chk("zero_bcd", r_bcd, 16'h0000);
    chk("zero_ovf", r_ovf, 0);
    chk("zero_neg", r_neg, 0);
    // sign-sensitive vectors
    conv_a(12'h800, 1'b1);
    chk("h800_bcd", r_bcd, 16'h2048);
    chk("h800_neg", r_neg, SGN);
    conv_a(12'h7FF, 1'b1);
    chk("h7ff_bcd", r_bcd, 16'h2047);
    chk("h7ff_neg", r_neg, 0);
    conv_a(12'hFFE, 1'b1);
    chk("hffe_bcd", r_bcd, SGN ? 16'h0002 : 16'h4094);
    chk("hffe_neg", r_neg, SGN);
    // 14-bit instance: overflow boundary
    conv_b(14'd9999);
    chk("w14_lat", lat, 15);
    chk("w14_9999_bcd", r_bcd, SGN ? 16'h6385 : 16'h9999);
    chk("w14_9999_ovf", r_ovf, 0);
    chk("w14_9999_neg", r_neg, SGN);
    conv_b(14'd10000);
    chk("w14_10000_bcd", r_bcd, SGN ? 16'h6384 : 16'h9999);
    chk("w14_10000_ovf", r_ovf, SGN ? 0 : 1);
    conv_b(14'd16383);
    chk("w14_16383_bcd", r_bcd, SGN ? 16'h0001 : 16'h9999);
    chk("w14_16383_ovf", r_ovf, SGN ? 0 : 1);
    conv_b(14'd8191);
    chk("w14_8191_bcd", r_bcd, 16'h8191);
    chk("w14_8191_ovf", r_ovf, 0);
    // backpressure in HOLD
    conv_a(12'd1999, 1'b0);
    chk("bp_bcd", r_bcd, 16'h1999);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 12'd7;
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_bcd", out_bcd, 16'h1999);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    conv_a(12'd7, 1'b1);
    chk("bp_next_bcd", r_bcd, 16'h0007);
    // reset during the 6th CONV cycle
    in_valid = 1'b1; in_data = 12'd2748;
    @(negedge clk);
    in_valid = 1'b0;
    chk("conv_busy", busy, 1);
    chk("conv_in_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_bcd", out_bcd, 0);
    chk("mid_rst_ovf", out_ovf, 0);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= out_valid; end
    chk("mid_rst_no_result", seen, 0);
    conv_a(12'd1234, 1'b1);
    chk("after_rst_bcd", r_bcd, 16'h1234);
    // back-to-back with in_valid and out_ready held high
    in_data = vals[0]; in_valid = 1'b1; out_ready = 1'b1; last = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      w = 0;
      while (!out_valid && w < 100) begin @(negedge clk); w++; end
      m = mdl(int'(vals[k]), 12);
      chk("b2b_seen", out_valid, 1);
      chk("b2b_bcd", out_bcd, m[15:0]);
      chk("b2b_ovf", out_ovf, m[16]);
      chk("b2b_neg", out_neg, m[17]);
      if (k > 0) chk("b2b_spacing", cyc - last, 15);
      last = cyc;
      if (k < 9) in_data = vals[k+1]; else in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", in_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
